// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: deframes 11-bit frames and folds E0/F0 prefixes
// into make/break and extended flags on a single-cycle valid pulse.
module ps2_scan_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       valid,
    output logic       makeBreak,
    output logic [7:0] outCode,
    output logic       extended,
    output logic       frameErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   brk_pend_q, brk_pend_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [7:0]             code_q, code_d;
    logic                   mb_q, mb_d;
    logic                   ext_q, ext_d;

    logic clk_s;
    logic data_s;
    logic fall;
    logic timeout;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    assign valid     = valid_q;
    assign frameErr  = err_q;
    assign outCode   = code_q;
    assign makeBreak = mb_q;
    assign extended  = ext_q;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2Data};
        clk_prev_d  = clk_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        brk_pend_d  = brk_pend_q;
        ext_pend_d  = ext_pend_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        mb_d        = mb_q;
        ext_d       = ext_q;

        // Watchdog only runs between falling edges of an open frame
        if (state_q == IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_MAX);

        unique case (state_q)
            IDLE: begin
                if (fall && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = data_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && (^shift_q ^ par_q)) begin
                        if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            valid_d    = 1'b1;
                            code_d     = shift_q;
                            mb_d       = ~brk_pend_q;
                            ext_d      = ext_pend_q;
                            brk_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Line idles high, so preload ones to avoid a phantom edge
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 8'h00;
            mb_q        <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            brk_pend_q  <= brk_pend_d;
            ext_pend_q  <= ext_pend_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            code_q      <= code_d;
            mb_q        <= mb_d;
            ext_q       <= ext_d;
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed + random PS/2 frames against a
// byte-level keyboard model, checked by a queue-based scoreboard.
module tb_ps2_scan_decoder;

    localparam int TO   = 300;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       extended;
    logic       frameErr;

    typedef struct {
        bit       err;
        bit [7:0] code;
        bit       mb;
        bit       ext;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_brk = 0;
    bit   m_ext = 0;

    ps2_scan_decoder #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2Clk(ps2Clk),
        .ps2Data(ps2Data),
        .valid(valid),
        .makeBreak(makeBreak),
        .outCode(outCode),
        .extended(extended),
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2Data = b;
        cycles(HALF);
        ps2Clk = 1'b0;
        cycles(HALF);
        ps2Clk = 1'b1;
    endtask

    // Keyboard-level model: decide the outcome of a whole byte up front
    task automatic model_byte(input bit [7:0] b, input bit bad);
        exp_t e;
        if (bad) begin
            e = '{err: 1, code: 0, mb: 0, ext: 0};
            exp_q.push_back(e);
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            e = '{err: 0, code: b, mb: !m_brk, ext: m_ext};
            exp_q.push_back(e);
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic send(input bit [7:0] b, input bit pflip, input bit stop);
        bit par;
        par = ~(^b) ^ pflip;
        model_byte(b, pflip || !stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        cycles(HALF);
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if (valid !== 1'b0 || frameErr !== 1'b0 || outCode !== 8'h00 ||
            makeBreak !== 1'b0 || extended !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got v=%b e=%b code=%h mb=%b ext=%b want all 0",
                     tag, valid, frameErr, outCode, makeBreak, extended);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && (valid || frameErr)) begin
            exp_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: v=%b err=%b code=%h want none",
                         valid, frameErr, outCode);
            end else begin
                e = exp_q.pop_front();
                if (e.err) begin
                    if (!(frameErr === 1'b1 && valid === 1'b0)) begin
                        n_bad++;
                        $display("FAIL frame_err: got v=%b err=%b want v=0 err=1",
                                 valid, frameErr);
                    end
                end else if (!(valid === 1'b1 && frameErr === 1'b0 &&
                               outCode === e.code && makeBreak === e.mb &&
                               extended === e.ext)) begin
                    n_bad++;
                    $display("FAIL code: got v=%b err=%b code=%h mb=%b ext=%b want v=1 err=0 code=%h mb=%b ext=%b",
                             valid, frameErr, outCode, makeBreak, extended,
                             e.code, e.mb, e.ext);
                end
            end
        end
    end

    initial begin
        int r;
        int p;
        bit [7:0] b;

        cycles(5);
        check_idle_outputs("reset_state");
        reset = 1'b0;
        cycles(5);

        // Reset mid-frame after 4 data bits
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        reset = 1'b1;
        cycles(3);
        check_idle_outputs("reset_mid_frame");
        reset = 1'b0;
        m_brk = 0;
        m_ext = 0;
        cycles(5);
        check_idle_outputs("after_reset_release");
        send(8'h1C, 0, 1);

        send(8'h1C, 0, 1);
        send(8'hF0, 0, 1);
        send(8'h1C, 0, 1);
        send(8'h1C, 0, 1);
        send(8'hE0, 0, 1);
        send(8'hF0, 0, 1);
        send(8'h75, 0, 1);
        send(8'hE0, 0, 1);
        send(8'h75, 0, 1);
        send(8'h1C, 1, 1);
        send(8'h1C, 0, 0);
        send(8'hF0, 0, 1);
        send(8'h33, 1, 1);
        send(8'h1C, 0, 1);

        // Timeout after start + 3 data bits, with a pending break flag
        send(8'hF0, 0, 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        model_byte(8'h00, 1);
        cycles(TO + 50);
        send(8'h1C, 0, 1);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            p = $urandom_range(0, 19);
            if (r < 2) b = 8'hF0;
            else if (r < 4) b = 8'hE0;
            else b = 8'($urandom);
            send(b, p == 0, p != 1);
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected pulses never seen, want 0",
                     exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Receives the raw PS/2 keyboard serial stream (device-driven clock and data), deframes 11-bit frames, and resolves the E0/F0 prefix bytes. It emits one-cycle `valid` pulses carrying the scan code, a make/break flag and an extended flag. It sits directly upstream of the keyboard consumer logic (LED test / snake direction control), which acts on `valid & makeBreak` with `outCode`.

Parameters:
TIMEOUT_CYCLES, 50000, system-clock cycles with no PS/2 falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop stages synchronising ps2Clk and ps2Data into clk (minimum 2).

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
ps2Clk  input  1  raw PS/2 clock from keyboard, asynchronous
ps2Data  input  1  raw PS/2 data from keyboard, asynchronous
valid  output  1  one-cycle pulse: outCode/makeBreak/extended are valid
makeBreak  output  1  1 = key press (make), 0 = key release (break)
outCode  output  8  scan code byte (prefixes stripped)
extended  output  1  1 = code was preceded by E0
frameErr  output  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; bit counter, shift register, timeout counter and prefix flags cleared; valid=0, makeBreak=0, outCode=8'h00, extended=0, frameErr=0. Reset mid-frame discards the partial frame.
- Sync: ps2Clk and ps2Data each pass through SYNC_STAGES FFs, plus one extra ps2Clk register. `fall` = previous synced clk 1 and current synced clk 0. Data is sampled only on cycles where `fall`=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bitCnt=0. On fall with data=1, stay in IDLE (no error).
  - DATA: on each fall, shift data in LSB-first and increment bitCnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check that the stop bit is 1 and that odd parity holds (XOR of 8 data bits and parity bit = 1). Go to IDLE in both cases.
- Good byte at STOP (outputs registered; valid/frameErr high exactly one cycle, starting the cycle after the fall of the stop bit):
  - 8'hF0: set breakPending. No valid pulse.
  - 8'hE0: set extPending. No valid pulse.
  - Any other byte: valid=1, outCode=byte, makeBreak=~breakPending, extended=extPending. Clear both pending flags the same cycle.
  - E0 and F0 may arrive in either order and repeat; the flags are sticky until a code byte or an error.
- Bad parity or stop bit = 0: frameErr=1 for one cycle, byte discarded, both pending flags cleared, valid stays 0.
- Timeout: the counter resets to 0 on every fall and in IDLE, and increments otherwise. If it reaches TIMEOUT_CYCLES-1 while not in IDLE: FSM to IDLE, frameErr pulse, pending flags cleared, partial byte dropped. The counter saturates and does not wrap.
- Between pulses, outCode, makeBreak and extended hold their last values. Consumers must gate on valid.
- valid and frameErr are never high in the same cycle.
- Back-to-back frames: STOP to IDLE completes before the next start bit's fall, which is at least ~30 us away. No buffering is needed.

Test Plan:
1. Reset asserted mid-frame (after 4 data bits), then released → all outputs 0, FSM IDLE. The next full frame 0x1C decodes correctly.
2. Frame start 0, data 0x1C LSB-first (0,0,1,1,1,0,0,0), parity 0, stop 1 → one-cycle valid, outCode=8'h1C, makeBreak=1, extended=0, frameErr=0.
3. Frames F0 (parity 1), then 1C (parity 0) → no valid after F0. After 1C: valid=1, outCode=8'h1C, makeBreak=0, extended=0. A following plain 1C gives makeBreak=1.
4. Frames E0 (parity 0), F0, 75 (parity 0) → single valid with outCode=8'h75, makeBreak=0, extended=1. Then E0, 75 → makeBreak=1, extended=1.
5. Frame 0x1C with parity bit 1 → frameErr pulse, no valid. Frame with stop bit 0 → frameErr, no valid. F0 followed by a bad frame, then a good 1C → makeBreak=1 (flag cleared).
6. Start bit plus 3 data bits, then ps2Clk held high for TIMEOUT_CYCLES cycles → frameErr pulse once, FSM IDLE. The next full 1C frame decodes with valid=1, outCode=8'h1C.
